// File: rtl/register_block.sv
// register_block: per-lane general-purpose register file for an 8-lane SIMT
// core. Storage is mem[warp][lane][reg]; every lane has two combinational read
// ports and one clocked write port sharing one address per port and one warp
// selector.
// Optional feature: define REGISTER_BLOCK_WR_BYPASS_EN to forward same-cycle
// write data to a read port addressing the register being written.
module register_block #(
   parameter int DATA_W    = 64,
   parameter int NUM_REGS  = 16,
   parameter int NUM_WARPS = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(NUM_WARPS)-1:0] warp_selector,
   input  logic [7:0]                   read_en_0,
   input  logic [7:0]                   read_en_1,
   input  logic [$clog2(NUM_REGS)-1:0]  raddr_0,
   input  logic [$clog2(NUM_REGS)-1:0]  raddr_1,
   input  logic [7:0]                   write_en,
   input  logic [$clog2(NUM_REGS)-1:0]  waddr,
   input  logic [DATA_W-1:0]            wdata_0,
   input  logic [DATA_W-1:0]            wdata_1,
   input  logic [DATA_W-1:0]            wdata_2,
   input  logic [DATA_W-1:0]            wdata_3,
   input  logic [DATA_W-1:0]            wdata_4,
   input  logic [DATA_W-1:0]            wdata_5,
   input  logic [DATA_W-1:0]            wdata_6,
   input  logic [DATA_W-1:0]            wdata_7,
   output logic [DATA_W-1:0]            rdata_0_0,
   output logic [DATA_W-1:0]            rdata_0_1,
   output logic [DATA_W-1:0]            rdata_0_2,
   output logic [DATA_W-1:0]            rdata_0_3,
   output logic [DATA_W-1:0]            rdata_0_4,
   output logic [DATA_W-1:0]            rdata_0_5,
   output logic [DATA_W-1:0]            rdata_0_6,
   output logic [DATA_W-1:0]            rdata_0_7,
   output logic [DATA_W-1:0]            rdata_1_0,
   output logic [DATA_W-1:0]            rdata_1_1,
   output logic [DATA_W-1:0]            rdata_1_2,
   output logic [DATA_W-1:0]            rdata_1_3,
   output logic [DATA_W-1:0]            rdata_1_4,
   output logic [DATA_W-1:0]            rdata_1_5,
   output logic [DATA_W-1:0]            rdata_1_6,
   output logic [DATA_W-1:0]            rdata_1_7
);

   localparam int LANES = 8;

   logic [DATA_W-1:0] wdata   [LANES];
   logic [DATA_W-1:0] rdata_0 [LANES];
   logic [DATA_W-1:0] rdata_1 [LANES];
   logic [DATA_W-1:0] mem     [NUM_WARPS][LANES][NUM_REGS];

   // Gather the flat per-lane ports into arrays so the lane logic can loop.
   assign wdata[0] = wdata_0;
   assign wdata[1] = wdata_1;
   assign wdata[2] = wdata_2;
   assign wdata[3] = wdata_3;
   assign wdata[4] = wdata_4;
   assign wdata[5] = wdata_5;
   assign wdata[6] = wdata_6;
   assign wdata[7] = wdata_7;

   assign rdata_0_0 = rdata_0[0];
   assign rdata_0_1 = rdata_0[1];
   assign rdata_0_2 = rdata_0[2];
   assign rdata_0_3 = rdata_0[3];
   assign rdata_0_4 = rdata_0[4];
   assign rdata_0_5 = rdata_0[5];
   assign rdata_0_6 = rdata_0[6];
   assign rdata_0_7 = rdata_0[7];
   assign rdata_1_0 = rdata_1[0];
   assign rdata_1_1 = rdata_1[1];
   assign rdata_1_2 = rdata_1[2];
   assign rdata_1_3 = rdata_1[3];
   assign rdata_1_4 = rdata_1[4];
   assign rdata_1_5 = rdata_1[5];
   assign rdata_1_6 = rdata_1[6];
   assign rdata_1_7 = rdata_1[7];

   // Storage: asynchronous clear of every entry, then masked per-lane writes
   // into the selected warp only.
   // NOTE: the whole array is cleared on reset because reading a register
   // that was never written must return 0; this forces flops rather than a
   // RAM macro, and every sequential assignment is non-blocking so all lanes
   // update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARPS; w++)
            for (int l = 0; l < LANES; l++)
               for (int r = 0; r < NUM_REGS; r++)
                  mem[w][l][r] <= '0;
      end else begin
         for (int l = 0; l < LANES; l++)
            if (write_en[l])
               mem[warp_selector][l][waddr] <= wdata[l];
      end
   end

   // Combinational read ports: zero when disabled, optionally forwarding the
   // in-flight write when the read hits the register being written.
   // NOTE: outputs are defaulted before any condition so no path leaves them
   // unassigned, which would otherwise infer latches.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rdata_0[l] = '0;
         rdata_1[l] = '0;
         if (read_en_0[l]) rdata_0[l] = mem[warp_selector][l][raddr_0];
         if (read_en_1[l]) rdata_1[l] = mem[warp_selector][l][raddr_1];
`ifdef REGISTER_BLOCK_WR_BYPASS_EN
         if (read_en_0[l] && write_en[l] && (raddr_0 == waddr)) rdata_0[l] = wdata[l];
         if (read_en_1[l] && write_en[l] && (raddr_1 == waddr)) rdata_1[l] = wdata[l];
`endif
      end
   end

endmodule

// File: tb/tb_register_block.sv
// tb_register_block: randomized and directed self-checking bench for
// register_block against a warp/lane/register array reference model.
module tb_register_block;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  ws;
   logic [7:0]  re0, re1, we;
   logic [3:0]  ra0, ra1, wa;
   logic [63:0] wd  [8];
   logic [63:0] rd0 [8];
   logic [63:0] rd1 [8];

   logic [63:0] ref_mem [8][8][16];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   register_block dut (
      .clk(clk), .rst_n(rst_n), .warp_selector(ws),
      .read_en_0(re0), .read_en_1(re1), .raddr_0(ra0), .raddr_1(ra1),
      .write_en(we), .waddr(wa),
      .wdata_0(wd[0]), .wdata_1(wd[1]), .wdata_2(wd[2]), .wdata_3(wd[3]),
      .wdata_4(wd[4]), .wdata_5(wd[5]), .wdata_6(wd[6]), .wdata_7(wd[7]),
      .rdata_0_0(rd0[0]), .rdata_0_1(rd0[1]), .rdata_0_2(rd0[2]), .rdata_0_3(rd0[3]),
      .rdata_0_4(rd0[4]), .rdata_0_5(rd0[5]), .rdata_0_6(rd0[6]), .rdata_0_7(rd0[7]),
      .rdata_1_0(rd1[0]), .rdata_1_1(rd1[1]), .rdata_1_2(rd1[2]), .rdata_1_3(rd1[3]),
      .rdata_1_4(rd1[4]), .rdata_1_5(rd1[5]), .rdata_1_6(rd1[6]), .rdata_1_7(rd1[7])
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // Expected read value from the model: disabled -> 0, else stored value,
   // or the same-cycle write data when forwarding is built in.
   function automatic logic [63:0] model_read(input int p, input int l);
      logic       en;
      logic [3:0] a;
      en = (p == 0) ? re0[l] : re1[l];
      a  = (p == 0) ? ra0 : ra1;
      if (!en) return 64'd0;
`ifdef REGISTER_BLOCK_WR_BYPASS_EN
      if (rst_n && we[l] && (a == wa)) return wd[l];
`endif
      return ref_mem[ws][l][a];
   endfunction

   task automatic check_all(input string tag);
      #1;
      for (int l = 0; l < 8; l++) begin
         check($sformatf("%s_p0_l%0d", tag, l), rd0[l], model_read(0, l));
         check($sformatf("%s_p1_l%0d", tag, l), rd1[l], model_read(1, l));
      end
   endtask

   task automatic clear_model();
      for (int w = 0; w < 8; w++)
         for (int l = 0; l < 8; l++)
            for (int r = 0; r < 16; r++)
               ref_mem[w][l][r] = 64'd0;
   endtask

   // One clock edge: the model commits enabled lanes, then settle past it.
   task automatic step();
      @(posedge clk);
      if (rst_n)
         for (int l = 0; l < 8; l++)
            if (we[l]) ref_mem[ws][l][wa] = wd[l];
      #1;
   endtask

   task automatic write_all(input logic [2:0] w, input logic [3:0] r, input logic [63:0] d);
      ws = w; wa = r; we = 8'hFF;
      for (int l = 0; l < 8; l++) wd[l] = d;
      step();
      we = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      we = 8'hFF; wa = 4'd0;
      for (int l = 0; l < 8; l++) wd[l] = rand64();
      step();
      step();
      we = 8'h00;
      rst_n = 1'b1;
   endtask

   logic [63:0] a_val, b_val, old_val, new_val;

   initial begin
      rst_n = 1'b1; ws = '0; re0 = '0; re1 = '0; we = '0;
      ra0 = '0; ra1 = '0; wa = '0;
      for (int l = 0; l < 8; l++) wd[l] = '0;
      clear_model();
      #2;
      rst_n = 1'b0;

      // Reset: every port reads 0 for any address/warp, enabled or not.
      re0 = 8'hFF; re1 = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         ws = 3'($urandom); ra0 = 4'($urandom); ra1 = 4'($urandom);
         check_all("reset_en");
      end
      re0 = 8'h00; re1 = 8'h00;
      check_all("reset_dis");
      do_reset();
      re0 = 8'hFF; re1 = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         ws = 3'($urandom); ra0 = 4'($urandom); ra1 = 4'($urandom);
         check_all("post_reset");
      end

      // Full sweep: every warp and register, port 0, port 1, then both.
      for (int w = 0; w < 8; w++) begin
         for (int r = 0; r < 16; r++) begin
            ws = 3'(w); wa = 4'(r); we = 8'hFF; re0 = 0; re1 = 0;
            for (int l = 0; l < 8; l++) wd[l] = rand64();
            step();
            we = 8'h00; ra0 = 4'(r); ra1 = 4'(r);
            re0 = 8'hFF; re1 = 8'h00; check_all("sweep_p0");
            re0 = 8'h00; re1 = 8'hFF; check_all("sweep_p1");
            re0 = 8'hFF; re1 = 8'hFF; check_all("sweep_both");
         end
      end

      // Lane masking: full write A then lower-half write B to reg 3.
      a_val = rand64(); b_val = rand64();
      write_all(3'd0, 4'd3, a_val);
      ws = 3'd0; wa = 4'd3; we = 8'h0F;
      for (int l = 0; l < 8; l++) wd[l] = b_val;
      step();
      we = 8'h00; ra0 = 4'd3; re0 = 8'hFF; re1 = 8'h00;
      #1;
      for (int l = 0; l < 8; l++)
         check($sformatf("lane_mask_l%0d", l), rd0[l], (l < 4) ? b_val : a_val);

      // Mid-operation reset wipes contents and ignores writes while low.
      do_reset();
      re0 = 8'hFF; re1 = 8'hFF; ws = 3'd0; ra0 = 4'd3; ra1 = 4'd0;
      #1;
      check("midreset_clear", rd0[0], 64'd0);
      check("midreset_nowrite", rd1[7], 64'd0);

      // Warp isolation.
      write_all(3'd2, 4'd5, 64'h1111);
      ws = 3'd3; ra0 = 4'd5; re0 = 8'hFF; #1;
      check("warp3_isolated", rd0[4], 64'd0);
      ws = 3'd2; #1;
      check("warp2_back", rd0[4], 64'h1111);

      // Dual-port, different addresses; port 1 disabled forces zero.
      a_val = rand64(); b_val = rand64();
      write_all(3'd2, 4'd1, a_val);
      write_all(3'd2, 4'd2, b_val);
      ws = 3'd2; ra0 = 4'd1; ra1 = 4'd2; re0 = 8'hFF; re1 = 8'hFF; #1;
      check("dual_p0", rd0[6], a_val);
      check("dual_p1", rd1[6], b_val);
      re1 = 8'h00; #1;
      check("dual_p1_off", rd1[6], 64'd0);
      check("dual_p0_on", rd0[6], a_val);

      // Same-cycle read and write to one address.
      old_val = rand64(); new_val = rand64();
      write_all(3'd4, 4'd7, old_val);
      ws = 3'd4; wa = 4'd7; ra0 = 4'd7; re0 = 8'hFF; re1 = 8'h00; we = 8'hFF;
      for (int l = 0; l < 8; l++) wd[l] = new_val;
      #1;
`ifdef REGISTER_BLOCK_WR_BYPASS_EN
      check("same_cycle_pre", rd0[2], new_val);
`else
      check("same_cycle_pre", rd0[2], old_val);
`endif
      step();
      we = 8'h00; #1;
      check("same_cycle_post", rd0[2], new_val);

      // Randomized traffic with a narrow address range to provoke hits.
      for (int i = 0; i < 400; i++) begin
         ws  = 3'($urandom_range(0, 7));
         re0 = 8'($urandom); re1 = 8'($urandom); we = 8'($urandom);
         ra0 = 4'($urandom_range(0, 3)); ra1 = 4'($urandom_range(0, 3));
         wa  = 4'($urandom_range(0, 3));
         for (int l = 0; l < 8; l++) wd[l] = rand64();
         check_all("rand");
         step();
      end
      we = 8'h00;
      check_all("rand_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
